// File: rtl/williams_io_pkg.sv
// Shared types and defaults for the data_io <-> SDRAM port 1 bridge.
package williams_io_pkg;

  localparam int unsigned ADDR_W     = 23;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned IOA_W      = 25;
  localparam int unsigned CMOS_OFS_W = 10;
  localparam int unsigned PAGE_W     = ADDR_W - CMOS_OFS_W;

  localparam logic [ADDR_W-1:0] CMOS_BASE_DFLT   = 23'h1CC00;
  localparam logic [PAGE_W-1:0] ROM_CMOS_HI_DFLT = 13'h0034;
  localparam logic [7:0]        NV_INDEX_DFLT    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } bridge_state_e;

  // One pending SDRAM access: {we, addr, data}, 40 bits.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } hold_entry_t;

  // Each nibble is stored twice so the 8-bit CMOS byte survives 16-bit SDRAM lanes.
  function automatic logic [DATA_W-1:0] nibble_dup(input logic [7:0] b);
    return {b[7:4], b[7:4], b[3:0], b[3:0]};
  endfunction

endpackage

// File: rtl/ioctl_sdram_bridge_if.sv
// data_io transfer signals and SDRAM port 1 signals seen by the bridge.
interface ioctl_sdram_bridge_if;
  import williams_io_pkg::*;

  logic              ioctl_download;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [IOA_W-1:0]  ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_din;

  logic              port1_req;
  logic              port1_ack;
  logic [ADDR_W-1:0] port1_a;
  logic              port1_we;
  logic [1:0]        port1_ds;
  logic [DATA_W-1:0] port1_d;
  logic [DATA_W-1:0] port1_q;

  // Bridge side: consumes ioctl, masters SDRAM port 1.
  modport master (
    input  ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_din,
    output port1_req, port1_a, port1_we, port1_ds, port1_d,
    input  port1_ack, port1_q
  );

  // Environment side: data_io plus the SDRAM controller.
  modport slave (
    output ioctl_download, ioctl_upload, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_din,
    input  port1_req, port1_a, port1_we, port1_ds, port1_d,
    output port1_ack, port1_q
  );

endinterface

// File: rtl/ioctl_addr_remap.sv
// Maps ioctl byte addresses onto SDRAM words, folding CMOS images into the CMOS window.
module ioctl_addr_remap
  import williams_io_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CMOS_BASE   = CMOS_BASE_DFLT,
  parameter logic [PAGE_W-1:0] ROM_CMOS_HI = ROM_CMOS_HI_DFLT,
  parameter logic [7:0]        NV_INDEX    = NV_INDEX_DFLT
) (
  input  logic [7:0]        index,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_c
);

  logic cmos_hit_c;

  // CMOS hit: D000-D3FF slice of the ROM file, or a standalone NVRAM transfer.
  always_comb begin
    cmos_hit_c = ((index == 8'h00) && (addr[ADDR_W-1:CMOS_OFS_W] == ROM_CMOS_HI)) ||
                 (index == NV_INDEX);
    addr_c     = cmos_hit_c ? (CMOS_BASE | ADDR_W'(addr[CMOS_OFS_W-1:0])) : addr;
  end

endmodule

// File: rtl/ioctl_sdram_bridge.sv
// Handshaked engine turning ioctl downloads/uploads into SDRAM port 1 toggle requests.
module ioctl_sdram_bridge
  import williams_io_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CMOS_BASE   = CMOS_BASE_DFLT,
  parameter logic [PAGE_W-1:0] ROM_CMOS_HI = ROM_CMOS_HI_DFLT,
  parameter logic [7:0]        NV_INDEX    = NV_INDEX_DFLT
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  ioctl_sdram_bridge_if.master bus,
  output logic                 busy,
  output logic                 overrun
);

  bridge_state_e         state_q, state_d;
  hold_entry_t           hold_q, hold_d;
  logic                  hold_v_q, hold_v_d;
  logic                  wr_q, wr_d;
  logic                  dl_q, dl_d;
  logic                  up_q, up_d;
  logic [CMOS_OFS_W-1:0] addr_prev_q, addr_prev_d;
  logic                  req_q, req_d;
  logic [ADDR_W-1:0]     a_q, a_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     d_q, d_d;
  logic [7:0]            din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  ovr_q, ovr_d;

  logic [ADDR_W-1:0]     remap_a_c;
  logic                  wr_rise_c;
  logic                  up_cap_c;
  logic                  consume_c;
  hold_entry_t           cap_entry_c;
  logic                  unused_bits;

  assign unused_bits = ^{bus.ioctl_addr[IOA_W-1:ADDR_W], bus.port1_q[15:12], bus.port1_q[7:4]};

  ioctl_addr_remap #(
    .CMOS_BASE   (CMOS_BASE),
    .ROM_CMOS_HI (ROM_CMOS_HI),
    .NV_INDEX    (NV_INDEX)
  ) u_remap (
    .index  (bus.ioctl_index),
    .addr   (bus.ioctl_addr[ADDR_W-1:0]),
    .addr_c (remap_a_c)
  );

  // Capture sources: registered wr edge for downloads, first cycle/address change for uploads.
  always_comb begin
    wr_rise_c = bus.ioctl_wr & ~wr_q & bus.ioctl_download;
    up_cap_c  = bus.ioctl_upload &
                (~up_q | (bus.ioctl_addr[CMOS_OFS_W-1:0] != addr_prev_q));
    cap_entry_c.we   = wr_rise_c;
    cap_entry_c.addr = remap_a_c;
    cap_entry_c.data = wr_rise_c ? nibble_dup(bus.ioctl_dout) : '0;
  end

  // FSM next state, holding buffer and registered outputs.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    wr_d        = bus.ioctl_wr;
    dl_d        = bus.ioctl_download;
    up_d        = bus.ioctl_upload;
    addr_prev_d = bus.ioctl_addr[CMOS_OFS_W-1:0];
    req_d       = req_q;
    a_d         = a_q;
    we_d        = we_q;
    d_d         = d_q;
    din_d       = din_q;
    ovr_d       = ovr_q;
    consume_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_v_q) state_d = ISSUE;
      end
      ISSUE: begin
        a_d       = hold_q.addr;
        we_d      = hold_q.we;
        d_d       = hold_q.data;
        req_d     = ~req_q;
        hold_v_d  = 1'b0;
        consume_c = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.port1_ack == req_q) begin
          state_d = IDLE;
          if (!we_q) din_d = {bus.port1_q[11:8], bus.port1_q[3:0]};
        end
      end
      default: state_d = IDLE;
    endcase

    // A new transfer session forgets earlier losses.
    if ((bus.ioctl_download & ~dl_q) | (bus.ioctl_upload & ~up_q)) ovr_d = 1'b0;

    // Buffer is free if empty or drained this cycle; otherwise the newcomer is lost.
    if (wr_rise_c | up_cap_c) begin
      if (!hold_v_q || consume_c) begin
        hold_d   = cap_entry_c;
        hold_v_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE) | hold_v_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      wr_q        <= 1'b0;
      dl_q        <= 1'b0;
      up_q        <= 1'b0;
      addr_prev_q <= '0;
      req_q       <= 1'b0;
      a_q         <= '0;
      we_q        <= 1'b0;
      d_q         <= '0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      wr_q        <= wr_d;
      dl_q        <= dl_d;
      up_q        <= up_d;
      addr_prev_q <= addr_prev_d;
      req_q       <= req_d;
      a_q         <= a_d;
      we_q        <= we_d;
      d_q         <= d_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.port1_req = req_q;
  assign bus.port1_a   = a_q;
  assign bus.port1_we  = we_q;
  assign bus.port1_d   = d_q;
  assign bus.port1_ds  = 2'b11;
  assign bus.ioctl_din = din_q;
  assign busy          = busy_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_ioctl_sdram_bridge.sv
// Self-checking bench for ioctl_sdram_bridge with a toggle-handshake SDRAM responder.
module tb_ioctl_sdram_bridge;
  import williams_io_pkg::*;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic busy;
  logic overrun;

  ioctl_sdram_bridge_if bus();

  ioctl_sdram_bridge dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        we;
    logic [22:0] a;
    logic [15:0] d;
  } req_t;

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [22:0] exp_a;
    logic [15:0] exp_d;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  bit          auto_ack;
  int          ack_lat;
  int          lat_cnt;
  logic        prev_req;
  logic [15:0] mem [int];
  req_t        log_q [$];

  // SDRAM controller model: logs each new request, acks after ack_lat cycles when enabled.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      bus.port1_ack = 1'b0;
      bus.port1_q   = 16'h0;
      prev_req      = 1'b0;
      lat_cnt       = 0;
    end else begin
      if (bus.port1_req !== prev_req) begin
        prev_req = bus.port1_req;
        log_q.push_back('{we: bus.port1_we, a: bus.port1_a, d: bus.port1_d});
      end
      if (auto_ack && (bus.port1_req !== bus.port1_ack)) begin
        if (lat_cnt >= ack_lat) begin
          if (bus.port1_we) mem[int'(bus.port1_a)] = bus.port1_d;
          else bus.port1_q = mem.exists(int'(bus.port1_a)) ? mem[int'(bus.port1_a)] : 16'h0;
          bus.port1_ack = bus.port1_req;
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end
    end
  end

  // Reference address rule, arithmetic form: CMOS window is base plus 10-bit offset.
  function automatic logic [22:0] model_remap(input logic [7:0] idx, input logic [24:0] addr);
    int unsigned page;
    page = (int'(addr) >> 10) & 32'h1FFF;
    if ((idx == 8'h00 && page == 32'h34) || idx == 8'hFF)
      return 23'(32'h1CC00 + (int'(addr) & 32'h3FF));
    return 23'(int'(addr) & 32'h7FFFFF);
  endfunction

  function automatic logic [15:0] model_data(input logic [7:0] b);
    return 16'((int'(b) / 16) * 32'h1100 + (int'(b) % 16) * 32'h11);
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic do_wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] dout,
                       input int gap);
    @(negedge clk_sys);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = addr;
    bus.ioctl_dout  = dout;
    bus.ioctl_wr    = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr    = 1'b0;
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      tick();
      if (!busy && (bus.port1_ack === bus.port1_req)) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout, busy=%0b expected 0", name, busy);
    end
  endtask

  task automatic pop_req(input string name, input logic we, input logic [22:0] a,
                         input logic [15:0] d);
    req_t r;
    if (log_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no request seen, expected a=%0h", name, a);
    end else begin
      r = log_q.pop_front();
      if (we) chk(name, {r.we, r.a, r.d}, {we, a, d});
      else    chk(name, {r.we, r.a, 16'h0}, {we, a, 16'h0});
    end
  endtask

  vec_t        vecs [8];
  logic [7:0]  r_idx;
  logic [24:0] r_addr;
  logic [7:0]  r_dout;
  logic [9:0]  offs [8];
  logic [7:0]  bytes [8];

  initial begin
    vecs[0] = '{8'h00, 25'h0000123, 8'hA5, 23'h00123, 16'hAA55};
    vecs[1] = '{8'h00, 25'h000D010, 8'h3C, 23'h1CC10, 16'h33CC};
    vecs[2] = '{8'h00, 25'h000D3FF, 8'h00, 23'h1CFFF, 16'h0000};
    vecs[3] = '{8'h00, 25'h000CFFF, 8'hFF, 23'h0CFFF, 16'hFFFF};
    vecs[4] = '{8'h00, 25'h000D400, 8'h5A, 23'h0D400, 16'h55AA};
    vecs[5] = '{8'h01, 25'h000D010, 8'h96, 23'h0D010, 16'h9966};
    vecs[6] = '{8'hFF, 25'h0012345, 8'h12, 23'h1CF45, 16'h1122};
    vecs[7] = '{8'h00, 25'h1800123, 8'hE7, 23'h00123, 16'hEE77};

    bus.ioctl_download = 1'b0;
    bus.ioctl_upload   = 1'b0;
    bus.ioctl_index    = 8'h00;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = 8'h00;
    auto_ack = 1'b1;
    ack_lat  = 0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk_sys);

    chk("rst_req", bus.port1_req, 0);
    chk("rst_a", bus.port1_a, 0);
    chk("rst_we", bus.port1_we, 0);
    chk("rst_d", bus.port1_d, 0);
    chk("rst_din", bus.ioctl_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ds", bus.port1_ds, 2'b11);
    reset_n = 1'b1;

    // Write latency and stability while the ack is held off.
    auto_ack = 1'b0;
    @(negedge clk_sys) bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_index = 8'h00; bus.ioctl_addr = 25'h0000123; bus.ioctl_dout = 8'hA5; bus.ioctl_wr = 1'b1;
    tick();
    chk("lat_busy_capture", busy, 1);
    chk("lat_req_capture", bus.port1_req, 0);
    @(negedge clk_sys) bus.ioctl_wr = 1'b0;
    tick();
    chk("lat_req_plus1", bus.port1_req, 0);
    tick();
    chk("lat_req_plus2", bus.port1_req, 1);
    chk("lat_a", bus.port1_a, 23'h00123);
    chk("lat_d", bus.port1_d, 16'hAA55);
    chk("lat_we", bus.port1_we, 1);
    tick(); tick();
    chk("wait_a_stable", bus.port1_a, 23'h00123);
    chk("wait_busy", busy, 1);
    auto_ack = 1'b1;
    tick();
    chk("busy_drop_after_ack", busy, 0);
    pop_req("lat_req", 1'b1, 23'h00123, 16'hAA55);

    // Table of remap/data vectors.
    for (int i = 0; i < 8; i++) begin
      do_wr(vecs[i].idx, vecs[i].addr, vecs[i].dout, 0);
      wait_idle($sformatf("vec%0d_idle", i));
      pop_req($sformatf("vec%0d", i), 1'b1, vecs[i].exp_a, vecs[i].exp_d);
    end

    // NVRAM upload over two addresses.
    mem[32'h1CC00] = 16'h0F05;
    mem[32'h1CC01] = 16'h0C0A;
    ack_lat = 2;
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_index = 8'hFF; bus.ioctl_addr = 25'h0; bus.ioctl_upload = 1'b1;
    wait_idle("up0_idle");
    pop_req("up_rd0", 1'b0, 23'h1CC00, 16'h0);
    chk("up_din0", bus.ioctl_din, 8'hF5);
    @(negedge clk_sys) bus.ioctl_addr = 25'h1;
    wait_idle("up1_idle");
    pop_req("up_rd1", 1'b0, 23'h1CC01, 16'h0);
    chk("up_din1", bus.ioctl_din, 8'hCA);
    repeat (3) tick();
    chk("up_no_reread", log_q.size(), 0);
    @(negedge clk_sys) bus.ioctl_upload = 1'b0;
    tick();
    chk("up_din_hold", bus.ioctl_din, 8'hCA);

    // Capture in the same cycle ISSUE drains the buffer is accepted.
    ack_lat = 0;
    @(negedge clk_sys) bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_index = 8'h00; bus.ioctl_addr = 25'h10; bus.ioctl_dout = 8'h11; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys) bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_addr = 25'h20; bus.ioctl_dout = 8'h22; bus.ioctl_wr = 1'b1;
    @(negedge clk_sys) bus.ioctl_wr = 1'b0;
    wait_idle("issue_cap_idle");
    pop_req("issue_cap_first", 1'b1, 23'h10, 16'h1111);
    pop_req("issue_cap_second", 1'b1, 23'h20, 16'h2222);
    chk("issue_cap_no_overrun", overrun, 0);

    // Three edges with the ack held: third is dropped.
    auto_ack = 1'b0;
    do_wr(8'h00, 25'h100, 8'h01, 1);
    do_wr(8'h00, 25'h200, 8'h02, 1);
    do_wr(8'h00, 25'h300, 8'h03, 1);
    tick();
    chk("ovr_set", overrun, 1);
    chk("ovr_one_issued", log_q.size(), 1);
    auto_ack = 1'b1;
    wait_idle("ovr_idle");
    pop_req("ovr_first", 1'b1, 23'h100, 16'h0011);
    pop_req("ovr_second", 1'b1, 23'h200, 16'h0022);
    chk("ovr_third_dropped", log_q.size(), 0);
    chk("ovr_sticky", overrun, 1);
    @(negedge clk_sys) bus.ioctl_download = 1'b0;
    tick();
    chk("ovr_kept_on_fall", overrun, 1);
    @(negedge clk_sys) bus.ioctl_download = 1'b1;
    tick();
    chk("ovr_clear_on_rise", overrun, 0);

    // Download ends while a request is in flight.
    auto_ack = 1'b0;
    do_wr(8'h00, 25'h400, 8'h77, 0);
    tick(); tick();
    @(negedge clk_sys) bus.ioctl_download = 1'b0;
    repeat (3) tick();
    chk("dl_end_busy", busy, 1);
    auto_ack = 1'b1;
    wait_idle("dl_end_idle");
    pop_req("dl_end_req", 1'b1, 23'h400, 16'h7777);
    chk("dl_end_busy_low", busy, 0);

    // Reset in WAIT.
    auto_ack = 1'b0;
    @(negedge clk_sys) bus.ioctl_download = 1'b1;
    do_wr(8'h00, 25'h500, 8'h99, 0);
    tick(); tick();
    chk("rstw_busy_before", busy, 1);
    @(negedge clk_sys) reset_n = 1'b0;
    #1;
    chk("rstw_req", bus.port1_req, 0);
    chk("rstw_a", bus.port1_a, 0);
    chk("rstw_we", bus.port1_we, 0);
    chk("rstw_d", bus.port1_d, 0);
    chk("rstw_din", bus.ioctl_din, 0);
    chk("rstw_busy", busy, 0);
    repeat (2) @(negedge clk_sys);
    log_q.delete();
    reset_n = 1'b1;
    auto_ack = 1'b1;
    do_wr(8'h00, 25'h600, 8'h42, 0);
    wait_idle("rstw_after_idle");
    pop_req("rstw_after_req", 1'b1, 23'h600, 16'h4422);

    // Randomized downloads against the address/data rules.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       r_idx = 8'h00;
        1:       r_idx = 8'hFF;
        default: r_idx = 8'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1)
        r_addr = {2'($urandom), 13'(32'h33 + $urandom_range(0, 2)), 10'($urandom)};
      else
        r_addr = 25'($urandom);
      r_dout  = 8'($urandom);
      ack_lat = int'($urandom_range(0, 3));
      do_wr(r_idx, r_addr, r_dout, 0);
      wait_idle($sformatf("rnd%0d_idle", i));
      pop_req($sformatf("rnd%0d", i), 1'b1, model_remap(r_idx, r_addr), model_data(r_dout));
    end

    // Random NVRAM bytes written then read back through an upload.
    for (int k = 0; k < 8; k++) begin
      offs[k]  = 10'(k * 100 + int'($urandom_range(0, 99)));
      bytes[k] = 8'($urandom);
      do_wr(8'hFF, {15'($urandom), offs[k]}, bytes[k], 0);
      wait_idle($sformatf("nvw%0d_idle", k));
      pop_req($sformatf("nvw%0d", k), 1'b1, model_remap(8'hFF, {15'h0, offs[k]}),
              model_data(bytes[k]));
    end
    @(negedge clk_sys) bus.ioctl_download = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_sys);
      bus.ioctl_index  = 8'hFF;
      bus.ioctl_addr   = {15'h0, offs[k]};
      bus.ioctl_upload = 1'b1;
      wait_idle($sformatf("nvr%0d_idle", k));
      pop_req($sformatf("nvr%0d", k), 1'b0, model_remap(8'hFF, {15'h0, offs[k]}), 16'h0);
      chk($sformatf("nvr%0d_din", k), bus.ioctl_din, bytes[k]);
    end
    @(negedge clk_sys) bus.ioctl_upload = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
